// File: rtl/debug_autobaud_pkg.sv
// Shared types and helpers for the multi-channel auto-baud detector.
// Optional feature macro used by this slice: AUTOBAUD_BREAK_REARM_EN.
package debug_autobaud_pkg;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   // Width of the 1-based channel select (0 reserved for "no channel").
   function automatic int sel_width(input int num_rx);
      return $clog2(num_rx + 1);
   endfunction

   // Top div_w bits of a cnt_w-bit pulse-width count.
   function automatic int unsigned sample_of(input int unsigned cnt,
                                             input int unsigned cnt_w,
                                             input int unsigned div_w);
      return cnt >> (cnt_w - div_w);
   endfunction

   // Unsigned magnitude of the difference between two samples.
   function automatic int unsigned abs_diff(input int unsigned a,
                                            input int unsigned b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/debug_rx_sync.sv
// Per-channel RX synchroniser: two metastability flops plus a last-value
// flop for edge detection. All flops preset to 1 (idle UART line).
// With AUTOBAUD_BREAK_REARM_EN the synchronised level is also exported.
module debug_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic rx,
`ifdef AUTOBAUD_BREAK_REARM_EN
   output logic level_o,
`endif
   output logic edge_o
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic last_q,  last_d;

   // Shift the pin through the synchroniser and remember the previous level.
   always_comb begin
      sync1_d = rx;
      sync2_d = sync1_q;
      last_d  = sync2_q;
   end

   // Synchroniser registers, released to the idle-high line state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         last_q  <= 1'b1;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         last_q  <= last_d;
      end
   end

   assign edge_o = (sync2_q != last_q);
`ifdef AUTOBAUD_BREAK_REARM_EN
   assign level_o = sync2_q;
`endif

endmodule

// File: rtl/debug_autobaud_mc.sv
// Multi-channel auto-baud detector: locks to the first toggling RX channel,
// measures pulse widths and writes the divisor once MATCH_CNT samples agree.
// Optional macro AUTOBAUD_BREAK_REARM_EN: a line break on the locked channel
// re-arms the detector.
module debug_autobaud_mc
   import debug_autobaud_pkg::*;
#(
   parameter  int          NUM_RX    = 3,
   parameter  int          CNT_W     = 13,
   parameter  int          DIV_W     = 8,
   parameter  int          MATCH_CNT = 3,
   parameter  int unsigned TOL       = 0,
   localparam int          SEL_W     = sel_width(NUM_RX)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              disabled,
   input  logic              rearm,
   input  logic [NUM_RX-1:0] rx,
   output logic              wr,
   output logic [DIV_W-1:0]  div,
   output logic [SEL_W-1:0]  rx_sel,
   output logic              locked,
   output logic              busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t                            state_q, state_d;
   logic [SEL_W-1:0]                  cand_q, cand_d;
   logic [CNT_W-1:0]                  cnt_q, cnt_d;
   logic [MATCH_CNT-1:0][DIV_W-1:0]   hist_q, hist_d;
   logic [MATCH_CNT-1:0]              hval_q, hval_d;
   logic                              chk_q, chk_d;
   logic [DIV_W-1:0]                  div_q, div_d;
   logic [SEL_W-1:0]                  rx_sel_q, rx_sel_d;
   logic                              wr_q, wr_d;

   logic [NUM_RX-1:0]                 edge_vec;
   logic [SEL_W-1:0]                  first_sel;
   logic                              cand_edge;
   logic                              lock_ok;
   logic                              break_hit;
   logic                              do_rearm;
   logic [DIV_W-1:0]                  sample;

`ifdef AUTOBAUD_BREAK_REARM_EN
   logic [NUM_RX-1:0]                 lvl_vec;
   logic                              sel_lvl;
`endif

   for (genvar i = 0; i < NUM_RX; i++) begin : g_sync
      debug_rx_sync u_sync (
         .clk     (clk),
         .rst_n   (rst_n),
         .rx      (rx[i]),
`ifdef AUTOBAUD_BREAK_REARM_EN
         .level_o (lvl_vec[i]),
`endif
         .edge_o  (edge_vec[i])
      );
   end

   assign sample = DIV_W'(sample_of(32'(cnt_q), CNT_W, DIV_W));

   // Lowest-index edging channel, 1-based (0 when no edge).
   always_comb begin
      first_sel = '0;
      for (int i = NUM_RX - 1; i >= 0; i--) begin
         if (edge_vec[i]) first_sel = SEL_W'(i + 1);
      end
   end

   // Edge on the candidate channel only; other channels are ignored.
   always_comb begin
      cand_edge = 1'b0;
      for (int i = 0; i < NUM_RX; i++) begin
         if (cand_q == SEL_W'(i + 1)) cand_edge = edge_vec[i];
      end
   end

   // Lock condition: history full and every entry within TOL of the newest.
   always_comb begin
      lock_ok = &hval_q;
      for (int k = 1; k < MATCH_CNT; k++) begin
         if (abs_diff(32'(hist_q[k]), 32'(hist_q[0])) > TOL) lock_ok = 1'b0;
      end
   end

`ifdef AUTOBAUD_BREAK_REARM_EN
   // Synchronised level of the locked channel, idle-high when none selected.
   always_comb begin
      sel_lvl = 1'b1;
      for (int i = 0; i < NUM_RX; i++) begin
         if (rx_sel_q == SEL_W'(i + 1)) sel_lvl = lvl_vec[i];
      end
   end
   assign break_hit = (state_q == LOCKED) && !sel_lvl && (cnt_q == CNT_MAX);
`else
   assign break_hit = 1'b0;
`endif

   assign do_rearm = rearm | break_hit;

   // Next-state logic: rearm first, then lock check, timeout, sampling.
   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      hist_d   = hist_q;
      hval_d   = hval_q;
      chk_d    = 1'b0;
      div_d    = div_q;
      rx_sel_d = rx_sel_q;
      wr_d     = 1'b0;
      if (do_rearm) begin
         state_d  = HUNT;
         cand_d   = '0;
         cnt_d    = '0;
         hval_d   = '0;
         rx_sel_d = '0;
      end else begin
         case (state_q)
            HUNT: begin
               if (|edge_vec) begin
                  cnt_d = '0;
                  if (disabled) begin
                     state_d  = LOCKED;
                     rx_sel_d = first_sel;
                  end else begin
                     state_d = MEASURE;
                     cand_d  = first_sel;
                  end
               end
            end
            MEASURE: begin
               if (chk_q && lock_ok) begin
                  state_d  = LOCKED;
                  div_d    = hist_q[0];
                  rx_sel_d = cand_q;
                  wr_d     = 1'b1;
                  cnt_d    = '0;
               end else if (cnt_q == CNT_MAX) begin
                  state_d = HUNT;
                  cand_d  = '0;
                  cnt_d   = '0;
                  hval_d  = '0;
               end else if (cand_edge) begin
                  cnt_d = '0;
                  if (sample == '0) begin
                     hval_d = '0;
                  end else begin
                     for (int k = MATCH_CNT - 1; k > 0; k--) hist_d[k] = hist_q[k-1];
                     hist_d[0] = sample;
                     hval_d    = {hval_q[MATCH_CNT-2:0], 1'b1};
                     chk_d     = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            LOCKED: begin
`ifdef AUTOBAUD_BREAK_REARM_EN
               if (sel_lvl) cnt_d = '0;
               else         cnt_d = cnt_q + 1'b1;
`endif
            end
            default: state_d = HUNT;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= HUNT;
         cand_q   <= '0;
         cnt_q    <= '0;
         hist_q   <= '0;
         hval_q   <= '0;
         chk_q    <= 1'b0;
         div_q    <= '0;
         rx_sel_q <= '0;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         hist_q   <= hist_d;
         hval_q   <= hval_d;
         chk_q    <= chk_d;
         div_q    <= div_d;
         rx_sel_q <= rx_sel_d;
         wr_q     <= wr_d;
      end
   end

   assign wr     = wr_q;
   assign div    = div_q;
   assign rx_sel = rx_sel_q;
   assign locked = (state_q == LOCKED);
   assign busy   = (state_q == MEASURE);

endmodule

// File: tb/tb_debug_autobaud_mc.sv
// Directed bench for debug_autobaud_mc. Two instances share stimulus:
// dut0 with TOL=0 and dut1 with TOL=1. Honours AUTOBAUD_BREAK_REARM_EN.
module tb_debug_autobaud_mc;

   logic       clk;
   logic       rst_n;
   logic       disabled;
   logic       rearm;
   logic [2:0] rx;

   logic       wr0, locked0, busy0;
   logic [7:0] div0;
   logic [1:0] rx_sel0;
   logic       wr1, locked1, busy1;
   logic [7:0] div1;
   logic [1:0] rx_sel1;

   int checks;
   int passes;
   int wr0Count;
   int wr1Count;

   debug_autobaud_mc #(.TOL(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .disabled(disabled), .rearm(rearm), .rx(rx),
      .wr(wr0), .div(div0), .rx_sel(rx_sel0), .locked(locked0), .busy(busy0)
   );

   debug_autobaud_mc #(.TOL(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .disabled(disabled), .rearm(rearm), .rx(rx),
      .wr(wr1), .div(div1), .rx_sel(rx_sel1), .locked(locked1), .busy(busy1)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count divisor write strobes away from the active edge.
   always @(negedge clk) begin
      if (wr0) wr0Count++;
      if (wr1) wr1Count++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp)
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      else
         passes++;
   endtask

   // Toggle one RX channel, then hold for the given number of clocks.
   task automatic applyStimulus(input int ch, input int width);
      rx[ch] = ~rx[ch];
      repeat (width) @(negedge clk);
   endtask

   task automatic pulseRearm();
      rearm = 1'b1;
      @(negedge clk);
      rearm = 1'b0;
      repeat (4) @(negedge clk);
      wr0Count = 0;
      wr1Count = 0;
   endtask

   initial begin
      checks   = 0;
      passes   = 0;
      wr0Count = 0;
      wr1Count = 0;
      rst_n    = 1'b0;
      disabled = 1'b0;
      rearm    = 1'b0;
      rx       = 3'b111;
      repeat (3) @(negedge clk);

      // Reset state
      checkOutput("reset_wr",     32'(wr0),     0);
      checkOutput("reset_div",    32'(div0),    0);
      checkOutput("reset_rx_sel", 32'(rx_sel0), 0);
      checkOutput("reset_locked", 32'(locked0), 0);
      checkOutput("reset_busy",   32'(busy0),   0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("idle_busy", 32'(busy0), 0);

      // Test 1: rx[1] toggles every 1024 clk, 5 edges -> samples of 31
      applyStimulus(1, 20);
      checkOutput("t1_busy", 32'(busy0), 1);
      repeat (1004) @(negedge clk);
      for (int i = 0; i < 4; i++) applyStimulus(1, 1024);
      checkOutput("t1_wr_count", 32'(wr0Count), 1);
      checkOutput("t1_div",      32'(div0),     31);
      checkOutput("t1_rx_sel",   32'(rx_sel0),  2);
      checkOutput("t1_locked",   32'(locked0),  1);
      checkOutput("t1_busy_off", 32'(busy0),    0);
      checkOutput("t1_wr_low",   32'(wr0),      0);

      // Rearm drops lock, divisor holds
      pulseRearm();
      checkOutput("rearm_locked", 32'(locked0), 0);
      checkOutput("rearm_rx_sel", 32'(rx_sel0), 0);
      checkOutput("rearm_div",    32'(div0),    31);

      // Test 2: rx[0] and rx[2] together; rx[2] then toggles mid-pulse
      rx[0] = ~rx[0];
      rx[2] = ~rx[2];
      for (int i = 0; i < 3; i++) begin
         repeat (512) @(negedge clk);
         rx[2] = ~rx[2];
         repeat (512) @(negedge clk);
         rx[0] = ~rx[0];
      end
      repeat (20) @(negedge clk);
      checkOutput("t2_rx_sel",   32'(rx_sel0),  1);
      checkOutput("t2_div",      32'(div0),     31);
      checkOutput("t2_wr_count", 32'(wr0Count), 1);
      checkOutput("t2_locked",   32'(locked0),  1);

      // Test 3: widths 1024/1056/1000 -> samples 31,32,31
      pulseRearm();
      applyStimulus(1, 1024);
      applyStimulus(1, 1056);
      applyStimulus(1, 1000);
      applyStimulus(1, 1024);
      checkOutput("t3_tol1_locked", 32'(locked1),  1);
      checkOutput("t3_tol1_div",    32'(div1),     31);
      checkOutput("t3_tol1_wr",     32'(wr1Count), 1);
      checkOutput("t3_tol0_nolock", 32'(locked0),  0);
      checkOutput("t3_tol0_busy",   32'(busy0),    1);
      applyStimulus(1, 1024);
      checkOutput("t3_tol0_still",  32'(locked0),  0);
      applyStimulus(1, 1024);
      checkOutput("t3_tol0_locked", 32'(locked0),  1);
      checkOutput("t3_tol0_div",    32'(div0),     31);
      checkOutput("t3_tol0_wr",     32'(wr0Count), 1);
      checkOutput("t3_tol1_wr_once", 32'(wr1Count), 1);

      // Test 4: one edge then idle -> timeout back to HUNT
      pulseRearm();
      applyStimulus(0, 50);
      checkOutput("t4_busy_on", 32'(busy0), 1);
      repeat (8250) @(negedge clk);
      checkOutput("t4_busy_off", 32'(busy0),    0);
      checkOutput("t4_unlocked", 32'(locked0),  0);
      checkOutput("t4_no_wr",    32'(wr0Count), 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 1024);
      checkOutput("t4_relock",   32'(locked0),  1);
      checkOutput("t4_rx_sel",   32'(rx_sel0),  1);
      checkOutput("t4_div",      32'(div0),     31);

      // Test 6a: reset mid-MEASURE clears outputs at once
      pulseRearm();
      applyStimulus(1, 100);
      checkOutput("t6_busy_pre", 32'(busy0), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("t6_busy_rst",   32'(busy0),   0);
      checkOutput("t6_div_rst",    32'(div0),    0);
      checkOutput("t6_rx_sel_rst", 32'(rx_sel0), 0);
      checkOutput("t6_locked_rst", 32'(locked0), 0);
      rx = 3'b111;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      wr0Count = 0;
      wr1Count = 0;

      // Test 5: bypass mode locks on first edge without a write
      disabled = 1'b1;
      applyStimulus(2, 20);
      checkOutput("t5_locked", 32'(locked0),  1);
      checkOutput("t5_rx_sel", 32'(rx_sel0),  3);
      checkOutput("t5_div",    32'(div0),     0);
      applyStimulus(2, 300);
      applyStimulus(2, 300);
      checkOutput("t5_no_wr",  32'(wr0Count), 0);
      pulseRearm();
      checkOutput("t5_rearm_locked", 32'(locked0), 0);
      checkOutput("t5_rearm_rx_sel", 32'(rx_sel0), 0);
      disabled = 1'b0;

`ifdef AUTOBAUD_BREAK_REARM_EN
      // Test 6b: line break on the locked channel re-arms
      for (int i = 0; i < 4; i++) applyStimulus(1, 1024);
      checkOutput("t6_break_pre", 32'(locked0), 1);
      rx[1] = 1'b0;
      repeat (8300) @(negedge clk);
      checkOutput("t6_break_locked", 32'(locked0), 0);
      checkOutput("t6_break_rx_sel", 32'(rx_sel0), 0);
      checkOutput("t6_break_div",    32'(div0),    31);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/debug_autobaud_mc.md
Name: debug_autobaud_mc

Overview:
Parametrised multi-channel auto-baud detector for the debug UART path; successor to the fixed 3-input detector. Watches NUM_RX candidate RX pins and locks to the first channel that toggles. Measures consecutive pulse widths on that channel and, once MATCH_CNT samples agree within TOL, writes the divisor to the baud generator once. Adds input synchronisers, channel locking, a timeout abort, tolerance matching, and a re-arm request.

Parameters:
NUM_RX, 3, number of candidate RX inputs (1..7)
CNT_W, 13, pulse-width counter width; saturates at all-ones
DIV_W, 8, divisor width; sample = count[CNT_W-1 -: DIV_W]
MATCH_CNT, 3, number of agreeing samples required for lock (2..4)
TOL, 0, maximum absolute sample difference accepted as a match

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
disabled  in  1  bypass: first edge locks the channel, no divisor write
rearm  in  1  one-cycle request to discard lock and re-hunt
rx  in  NUM_RX  asynchronous candidate RX inputs
wr  out  1  one-cycle divisor write strobe
div  out  DIV_W  locked divisor (newest accepted sample)
rx_sel  out  SEL_W=$clog2(NUM_RX+1)  selected channel, 1-based; 0 = none
locked  out  1  high in LOCKED state
busy  out  1  high in MEASURE state

Behaviour:
- Reset (async assert, sync release): state HUNT; wr=0, div=0, rx_sel=0, locked=0, busy=0; history cleared; counter 0; sync flops preset to 1 (idle line).
- Each rx bit passes a 2-flop synchroniser plus a last-value flop. edge[i] = sync[i] != last[i]. Latency from pin to edge is 2-3 clk.
- HUNT: on any edge, the lowest-index edging channel wins. Set cand=i+1, clear counter, go to MEASURE. If disabled=1, go directly to LOCKED instead: rx_sel=i+1, div unchanged, wr stays 0.
- MEASURE: only edges on cand are used; other channels are ignored. Counter increments on each cycle without an edge and saturates at 2^CNT_W-1. On a cand edge the counter clears.
  - Sample = top DIV_W bits of the counter, so a pulse of W clk yields (W-1)>>(CNT_W-DIV_W).
  - A sample of 0 is discarded and the history is cleared.
  - Any other sample shifts into the MATCH_CNT-deep history (newest at [0]).
- Timeout: if the counter reaches saturation in MEASURE, clear the history, set cand=0 and return to HUNT. A saturated value is never sampled.
- Lock check runs the cycle after a history shift. Condition: all MATCH_CNT entries are valid, and |h[k]-h[0]| <= TOL for every k. On lock, for exactly 1 cycle:
  - div=h[0], rx_sel=cand, wr=1, locked=1; next state LOCKED.
  - If a cand edge arrives in the same cycle, the lock still wins and the edge is ignored.
- LOCKED: rx edges are ignored; wr=0; div and rx_sel hold.
- rearm=1 in any state takes priority over all other events. It sends the block to HUNT: history cleared, rx_sel=0, locked=0, wr=0; div holds its last value.
- disabled sampled high while in MEASURE has no effect until the next HUNT.
- Width rules: differences are computed in DIV_W+1 bits, unsigned magnitude.

Optional Feature:
AUTOBAUD_BREAK_REARM_EN
- Defined: in LOCKED, the selected channel held low for 2^CNT_W consecutive clk (line break) triggers an internal rearm. The counter is reused; it resets on any high sample.
- Undefined: LOCKED is left only via rearm or reset; the counter is idle in LOCKED.

Decomposition:
- Package debug_autobaud_pkg: state enum (HUNT=2'd0, MEASURE=2'd1, LOCKED=2'd2), SEL_W function/localparam, sample-extract and abs-diff helper functions.
- One sub-module, debug_rx_sync: per-channel 2-flop synchroniser plus edge detect, instantiated in a generate loop over NUM_RX.

Test Plan:
1. Defaults; toggle rx[1] every 1024 clk for 5 edges -> samples 31, 31, 31; wr pulses once with div=31, rx_sel=2, locked=1.
2. rx[0] and rx[2] toggle in the same cycle -> rx_sel=1 on lock; rx[2] activity has no effect.
3. TOL=1, pulse widths 1024/1056/1000 clk (samples 31, 32, 31) -> lock, div=31. Same widths with TOL=0 -> no lock until three exact samples.
4. One edge, then rx held idle for 8192 clk -> busy drops, back to HUNT, no wr. A later valid burst locks normally.
5. disabled=1, toggle rx[2] -> locked=1, rx_sel=3, wr never asserted, div=0. Then pulse rearm -> locked=0, rx_sel=0.
6. Assert rst_n low mid-MEASURE -> all outputs 0 immediately. With AUTOBAUD_BREAK_REARM_EN defined, hold the locked channel low for 8192 clk -> locked drops, re-hunt.
